// File: rtl/ibex_pkg.sv
// Shared fetch-path types and constants for the Ibex fetch realignment logic.
package ibex_pkg;

  localparam int unsigned FETCH_FIFO_DEPTH = 3;

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
  } fetch_entry_t;

  // A halfword opens a 16-bit instruction unless its low two bits are 2'b11.
  function automatic logic is_compressed(input logic [1:0] h_lsbs);
    return h_lsbs != 2'b11;
  endfunction

endpackage

// File: rtl/ibex_fetch_realign.sv
// Fetch FIFO that stores aligned 32-bit memory words and presents one
// (possibly compressed, possibly word-straddling) instruction per cycle.
module ibex_fetch_realign import ibex_pkg::*; #(
  parameter int unsigned DEPTH     = FETCH_FIFO_DEPTH,
  parameter logic [31:0] BOOT_ADDR = 32'h0000_0000
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        clear_i,
  input  logic [31:0] clear_addr_i,
  input  logic        in_valid_i,
  output logic        in_ready_o,
  input  logic [31:0] in_rdata_i,
  input  logic        in_err_i,
  output logic        out_valid_o,
  input  logic        out_ready_i,
  output logic [31:0] out_rdata_o,
  output logic [31:0] out_addr_o,
  output logic        out_err_o
);

  localparam int unsigned CW = $clog2(DEPTH + 1);

  fetch_entry_t  fifo_q [DEPTH];
  fetch_entry_t  fifo_d [DEPTH];
  logic [CW-1:0] count_q, count_d;
  logic [31:0]   pc_q, pc_d;

  logic          valid0, valid1;
  logic          valid_raw;
  logic [31:0]   rdata_raw;
  logic          err_raw;
  logic          instr_compressed;
  logic          fire, pop, push;
  logic [CW-1:0] wr_idx;

  assign valid0     = count_q != '0;
  assign valid1     = count_q > CW'(1);
  assign in_ready_o = count_q < CW'(DEPTH);

  // Realign mux: select the instruction starting at pc_q within the head word(s).
  always_comb begin
    valid_raw        = 1'b0;
    rdata_raw        = '0;
    err_raw          = 1'b0;
    instr_compressed = 1'b0;
    if (!pc_q[1]) begin
      instr_compressed = is_compressed(fifo_q[0].rdata[1:0]);
      valid_raw        = valid0;
      err_raw          = fifo_q[0].err;
      rdata_raw        = instr_compressed ? {16'h0, fifo_q[0].rdata[15:0]}
                                          : fifo_q[0].rdata;
    end else begin
      instr_compressed = is_compressed(fifo_q[0].rdata[17:16]);
      if (instr_compressed || fifo_q[0].err) begin
        // An errored head word is reported alone so outputs stay stable
        // if the next word arrives during a stall.
        valid_raw = valid0;
        err_raw   = fifo_q[0].err;
        rdata_raw = {16'h0, fifo_q[0].rdata[31:16]};
      end else begin
        valid_raw = valid0 & valid1;
        err_raw   = fifo_q[1].err;
        rdata_raw = {fifo_q[1].rdata[15:0], fifo_q[0].rdata[31:16]};
      end
    end
  end

  assign out_valid_o = valid_raw & ~clear_i;
  assign out_rdata_o = valid_raw ? rdata_raw : 32'h0;
  assign out_err_o   = valid_raw & err_raw;
  assign out_addr_o  = pc_q;

  assign fire   = out_valid_o & out_ready_i;
  assign pop    = fire & (pc_q[1] | ~instr_compressed);
  assign push   = in_valid_i & in_ready_o & ~clear_i;
  assign wr_idx = count_q - CW'(pop);

  always_comb begin
    fifo_d  = fifo_q;
    count_d = count_q;
    pc_d    = pc_q;

    if (pop) begin
      for (int i = 0; i < int'(DEPTH) - 1; i++) begin
        fifo_d[i] = fifo_q[i+1];
      end
    end

    if (push) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        if (CW'(i) == wr_idx) begin
          fifo_d[i] = '{rdata: in_rdata_i, err: in_err_i};
        end
      end
    end

    count_d = count_q + CW'(push) - CW'(pop);

    if (fire) begin
      pc_d = pc_q + (instr_compressed ? 32'd2 : 32'd4);
    end

    if (clear_i) begin
      count_d = '0;
      pc_d    = clear_addr_i & 32'hFFFF_FFFE;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      count_q <= '0;
      pc_q    <= BOOT_ADDR & 32'hFFFF_FFFE;
      for (int i = 0; i < int'(DEPTH); i++) begin
        fifo_q[i] <= '0;
      end
    end else begin
      count_q <= count_d;
      pc_q    <= pc_d;
      fifo_q  <= fifo_d;
    end
  end

endmodule

// File: tb/tb_ibex_fetch_realign.sv
// Directed table-driven bench for ibex_fetch_realign plus a mid-transfer reset sequence.
module tb_ibex_fetch_realign;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        clear_i;
  logic [31:0] clear_addr_i;
  logic        in_valid_i;
  logic        in_ready_o;
  logic [31:0] in_rdata_i;
  logic        in_err_i;
  logic        out_valid_o;
  logic        out_ready_i;
  logic [31:0] out_rdata_o;
  logic [31:0] out_addr_o;
  logic        out_err_o;

  int checks = 0;
  int errors = 0;

  ibex_fetch_realign #(.DEPTH(3), .BOOT_ADDR(32'h0000_0080)) dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .clear_i      (clear_i),
    .clear_addr_i (clear_addr_i),
    .in_valid_i   (in_valid_i),
    .in_ready_o   (in_ready_o),
    .in_rdata_i   (in_rdata_i),
    .in_err_i     (in_err_i),
    .out_valid_o  (out_valid_o),
    .out_ready_i  (out_ready_i),
    .out_rdata_o  (out_rdata_o),
    .out_addr_o   (out_addr_o),
    .out_err_o    (out_err_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic        clr;
    logic [31:0] caddr;
    logic        iv;
    logic [31:0] idata;
    logic        ierr;
    logic        ordy;
    logic        e_irdy;
    logic        e_ov;
    logic [31:0] e_rd;
    logic [31:0] e_addr;
    logic        e_err;
  } vec_t;

  localparam int NV = 38;
  vec_t tbl [NV];

  function automatic vec_t v(input logic clr, input logic [31:0] caddr,
                             input logic iv, input logic [31:0] idata,
                             input logic ierr, input logic ordy,
                             input logic e_irdy, input logic e_ov,
                             input logic [31:0] e_rd, input logic [31:0] e_addr,
                             input logic e_err);
    vec_t r;
    r.clr = clr; r.caddr = caddr; r.iv = iv; r.idata = idata; r.ierr = ierr;
    r.ordy = ordy; r.e_irdy = e_irdy; r.e_ov = e_ov; r.e_rd = e_rd;
    r.e_addr = e_addr; r.e_err = e_err;
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  task automatic check_outs(input string tag, input logic irdy, input logic ov,
                            input logic [31:0] rd, input logic [31:0] addr, input logic er);
    check({tag, ".in_ready"},  {31'h0, in_ready_o},  {31'h0, irdy});
    check({tag, ".out_valid"}, {31'h0, out_valid_o}, {31'h0, ov});
    check({tag, ".out_rdata"}, out_rdata_o, rd);
    check({tag, ".out_addr"},  out_addr_o,  addr);
    check({tag, ".out_err"},   {31'h0, out_err_o},   {31'h0, er});
  endtask

  task automatic drive(input logic clr, input logic [31:0] caddr, input logic iv,
                       input logic [31:0] idata, input logic ierr, input logic ordy);
    clear_i = clr; clear_addr_i = caddr; in_valid_i = iv;
    in_rdata_i = idata; in_err_i = ierr; out_ready_i = ordy;
  endtask

  initial begin
    // clr caddr iv idata ierr ordy | irdy ov rdata addr err
    tbl[0]  = v(0, 0, 1, 32'h00A00093, 0, 1,  1, 0, 32'h0,        32'h80,  0);
    tbl[1]  = v(0, 0, 0, 0,            0, 1,  1, 1, 32'h00A00093, 32'h80,  0);
    tbl[2]  = v(0, 0, 0, 0,            0, 1,  1, 0, 32'h0,        32'h84,  0);
    tbl[3]  = v(0, 0, 1, 32'h45014581, 0, 0,  1, 0, 32'h0,        32'h84,  0);
    tbl[4]  = v(0, 0, 0, 0,            0, 1,  1, 1, 32'h00004581, 32'h84,  0);
    tbl[5]  = v(0, 0, 0, 0,            0, 1,  1, 1, 32'h00004501, 32'h86,  0);
    tbl[6]  = v(0, 0, 0, 0,            0, 1,  1, 0, 32'h0,        32'h88,  0);
    tbl[7]  = v(1, 32'h102, 1, 32'hDEADBEEF, 0, 1, 1, 0, 32'h0,   32'h88,  0);
    tbl[8]  = v(0, 0, 1, 32'h00931234, 0, 1,  1, 0, 32'h0,        32'h102, 0);
    tbl[9]  = v(0, 0, 0, 0,            0, 1,  1, 0, 32'h0,        32'h102, 0);
    tbl[10] = v(0, 0, 1, 32'h000000A0, 0, 1,  1, 0, 32'h0,        32'h102, 0);
    tbl[11] = v(0, 0, 0, 0,            0, 1,  1, 1, 32'h00A00093, 32'h102, 0);
    tbl[12] = v(1, 32'h200, 1, 32'h77777777, 0, 1, 1, 0, 32'h0,   32'h106, 0);
    tbl[13] = v(0, 0, 0, 0,            0, 1,  1, 0, 32'h0,        32'h200, 0);
    tbl[14] = v(0, 0, 1, 32'h11111113, 0, 0,  1, 0, 32'h0,        32'h200, 0);
    tbl[15] = v(0, 0, 1, 32'h22222223, 0, 0,  1, 1, 32'h11111113, 32'h200, 0);
    tbl[16] = v(0, 0, 1, 32'h33333333, 0, 0,  1, 1, 32'h11111113, 32'h200, 0);
    tbl[17] = v(0, 0, 1, 32'h44444443, 0, 0,  0, 1, 32'h11111113, 32'h200, 0);
    tbl[18] = v(0, 0, 0, 0,            0, 1,  0, 1, 32'h11111113, 32'h200, 0);
    tbl[19] = v(0, 0, 1, 32'h44444443, 0, 1,  1, 1, 32'h22222223, 32'h204, 0);
    tbl[20] = v(0, 0, 1, 32'h55555553, 0, 0,  1, 1, 32'h33333333, 32'h208, 0);
    tbl[21] = v(0, 0, 1, 32'h66666663, 0, 0,  0, 1, 32'h33333333, 32'h208, 0);
    tbl[22] = v(0, 0, 0, 0,            0, 1,  0, 1, 32'h33333333, 32'h208, 0);
    tbl[23] = v(0, 0, 0, 0,            0, 1,  1, 1, 32'h44444443, 32'h20C, 0);
    tbl[24] = v(0, 0, 0, 0,            0, 1,  1, 1, 32'h55555553, 32'h210, 0);
    tbl[25] = v(0, 0, 0, 0,            0, 1,  1, 0, 32'h0,        32'h214, 0);
    tbl[26] = v(1, 32'h302, 0, 0,      0, 1,  1, 0, 32'h0,        32'h214, 0);
    tbl[27] = v(0, 0, 1, 32'hFFFF0000, 1, 0,  1, 0, 32'h0,        32'h302, 0);
    tbl[28] = v(0, 0, 0, 0,            0, 0,  1, 1, 32'h0000FFFF, 32'h302, 1);
    tbl[29] = v(0, 0, 1, 32'hABCD1234, 0, 0,  1, 1, 32'h0000FFFF, 32'h302, 1);
    tbl[30] = v(0, 0, 0, 0,            0, 0,  1, 1, 32'h0000FFFF, 32'h302, 1);
    tbl[31] = v(0, 0, 0, 0,            0, 1,  1, 1, 32'h0000FFFF, 32'h302, 1);
    tbl[32] = v(0, 0, 0, 0,            0, 1,  1, 1, 32'h0000ABCD, 32'h306, 0);
    tbl[33] = v(0, 0, 0, 0,            0, 1,  1, 0, 32'h0,        32'h308, 0);
    tbl[34] = v(1, 32'hFFFFFFFD, 0, 0, 0, 1,  1, 0, 32'h0,        32'h308, 0);
    tbl[35] = v(0, 0, 1, 32'h00000013, 0, 1,  1, 0, 32'h0,        32'hFFFFFFFC, 0);
    tbl[36] = v(0, 0, 0, 0,            0, 1,  1, 1, 32'h00000013, 32'hFFFFFFFC, 0);
    tbl[37] = v(0, 0, 0, 0,            0, 1,  1, 0, 32'h0,        32'h00000000, 0);

    rst_i = 1'b1;
    drive(0, 0, 0, 0, 0, 0);
    #12;
    check_outs("reset", 1'b1, 1'b0, 32'h0, 32'h80, 1'b0);
    @(negedge clk_i);
    rst_i = 1'b0;
    @(posedge clk_i); #1;

    for (int n = 0; n < NV; n++) begin
      drive(tbl[n].clr, tbl[n].caddr, tbl[n].iv, tbl[n].idata, tbl[n].ierr, tbl[n].ordy);
      @(negedge clk_i);
      check_outs($sformatf("vec%0d", n), tbl[n].e_irdy, tbl[n].e_ov, tbl[n].e_rd,
                 tbl[n].e_addr, tbl[n].e_err);
      @(posedge clk_i); #1;
    end

    // Reset mid-transfer: stored words must be discarded.
    drive(1, 32'h400, 0, 0, 0, 0);
    @(posedge clk_i); #1;
    drive(0, 0, 1, 32'h11111113, 0, 0);
    @(posedge clk_i); #1;
    drive(0, 0, 1, 32'h22222223, 0, 0);
    @(negedge clk_i);
    check_outs("pre_rst", 1'b1, 1'b1, 32'h11111113, 32'h400, 1'b0);
    @(posedge clk_i); #3;
    drive(0, 0, 0, 0, 0, 1);
    rst_i = 1'b1;
    #1;
    check_outs("mid_rst", 1'b1, 1'b0, 32'h0, 32'h80, 1'b0);
    @(negedge clk_i);
    rst_i = 1'b0;
    @(posedge clk_i); #1;
    @(negedge clk_i);
    check_outs("post_rst", 1'b1, 1'b0, 32'h0, 32'h80, 1'b0);
    @(posedge clk_i); #1;
    drive(0, 0, 1, 32'h00500013, 0, 1);
    @(negedge clk_i);
    check_outs("post_rst_push", 1'b1, 1'b0, 32'h0, 32'h80, 1'b0);
    @(posedge clk_i); #1;
    drive(0, 0, 0, 0, 0, 1);
    @(negedge clk_i);
    check_outs("post_rst_out", 1'b1, 1'b1, 32'h00500013, 32'h80, 1'b0);
    @(posedge clk_i); #1;
    @(negedge clk_i);
    check_outs("post_rst_empty", 1'b1, 1'b0, 32'h0, 32'h84, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
